// File: rtl/spi_ctl_pkg.sv
// Shared types and constants for the SPI flash read controller.
// Register offsets follow the spi block's register map.
package spi_ctl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HOST  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_SKIP  = 3'd3,
      ST_POLL  = 3'd4,
      ST_RDLO  = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   localparam logic [2:0] REG_XFER  = 3'd0;
   localparam logic [2:0] REG_NEXT  = 3'd1;
   localparam logic [2:0] REG_READY = 3'd2;

   localparam logic [7:0] FLASH_DUMMY   = 8'hFF;
   localparam logic [7:0] CMD_READ_DFLT = 8'h03;

   // Byte sent at write step k of a read: opcode, three address bytes, then dummies.
   function automatic logic [7:0] issue_byte(input logic [2:0]  k,
                                             input logic [23:0] a,
                                             input logic [7:0]  cmd);
      logic [7:0] b;
      case (k)
         3'd0:    b = cmd;
         3'd1:    b = a[23:16];
         3'd2:    b = a[15:8];
         3'd3:    b = a[7:0];
         default: b = FLASH_DUMMY;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from req and the
// registered last-served port; advance records the current winner.
module spi_rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic [1:0] o_grant,
   output logic       o_last
);

   logic r_last;

   // Grant selection; on contention the port not served last wins.
   always_comb begin
      o_grant = 2'b00;
      case (i_req)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end

   // Last-served port register; resets to 1 so port 0 wins first.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last <= 1'b1;
      end else if (i_advance) begin
         r_last <= o_grant[1];
      end else begin
         r_last <= r_last;
      end
   end

   assign o_last = r_last;

endmodule

// File: rtl/spi_flash_arb.sv
// Shares one SPI NOR flash between two 16-bit read ports via 0x03 reads,
// with a host-lock mode that hands the raw spi register bus to the CPU.
module spi_flash_arb
   import spi_ctl_pkg::*;
#(
   parameter logic [1:0] SPI_SEL  = 2'd0,
   parameter logic [7:0] CMD_READ = CMD_READ_DFLT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [23:0] addr0,
   input  logic [23:0] addr1,
   output logic [1:0]  ack,
   output logic [15:0] rdata,
   input  logic        host_lock,
   output logic        host_granted,
   input  logic [2:0]  host_addr,
   input  logic [7:0]  host_data,
   input  logic [1:0]  host_sel,
   input  logic        host_read,
   input  logic        host_write,
   output logic [7:0]  host_rdata,
   output logic [2:0]  reg_addr,
   output logic [7:0]  reg_data_in,
   output logic [1:0]  reg_sel,
   output logic        reg_read,
   output logic        reg_write,
   input  logic [7:0]  reg_data_out
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_k;
   logic [2:0]  w_k_nxt;
   logic        r_win;
   logic        w_win_nxt;
   logic [23:0] r_addr;
   logic [23:0] w_addr_nxt;
   logic [15:0] r_rdata;
   logic [15:0] w_rdata_nxt;
   logic [1:0]  w_grant;
   logic        w_advance;
   logic        w_last;

   // The arbiter records the winner at grant time; nothing re-arbitrates before DONE.
   spi_rr_arb2 u_arb (
      .i_clk     (clk),
      .i_rst_n   (reset),
      .i_req     (req),
      .i_advance (w_advance),
      .o_grant   (w_grant),
      .o_last    (w_last)
   );

   // Sequencer state and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_k     <= 3'd0;
         r_win   <= 1'b0;
         r_addr  <= 24'd0;
         r_rdata <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         r_win   <= w_win_nxt;
         r_addr  <= w_addr_nxt;
         r_rdata <= w_rdata_nxt;
      end
   end

   // Next-state logic and spi register bus drive.
   always_comb begin
      w_state_nxt  = r_state;
      w_k_nxt      = r_k;
      w_win_nxt    = r_win;
      w_addr_nxt   = r_addr;
      w_rdata_nxt  = r_rdata;
      w_advance    = 1'b0;
      reg_addr     = REG_XFER;
      reg_data_in  = 8'h00;
      reg_sel      = SPI_SEL;
      reg_read     = 1'b0;
      reg_write    = 1'b0;
      ack          = 2'b00;
      host_granted = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (host_lock) begin
               w_state_nxt = ST_HOST;
            end else if (w_grant != 2'b00) begin
               w_win_nxt   = w_grant[1];
               w_addr_nxt  = w_grant[1] ? addr1 : addr0;
               w_k_nxt     = 3'd0;
               w_advance   = 1'b1;
               w_state_nxt = ST_ISSUE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_HOST: begin
            reg_addr     = host_addr;
            reg_data_in  = host_data;
            reg_sel      = host_sel;
            reg_read     = host_read;
            reg_write    = host_write;
            host_granted = 1'b1;
            if (!host_lock) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_HOST;
            end
         end
         ST_ISSUE: begin
            // Step 6 reads the high byte and closes the transaction in one access.
            if (r_k == 3'd6) begin
               reg_read    = 1'b1;
               reg_addr    = REG_XFER;
               w_rdata_nxt = {reg_data_out, r_rdata[7:0]};
            end else begin
               reg_write   = 1'b1;
               reg_addr    = (r_k == 3'd0) ? REG_XFER : REG_NEXT;
               reg_data_in = issue_byte(r_k, r_addr, CMD_READ);
            end
            w_state_nxt = ST_SKIP;
         end
         ST_SKIP: begin
            w_state_nxt = ST_POLL;
         end
         ST_POLL: begin
            reg_read = 1'b1;
            reg_addr = REG_READY;
            if (reg_data_out[0]) begin
               if (r_k == 3'd4) begin
                  w_state_nxt = ST_RDLO;
               end else if (r_k == 3'd6) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_k_nxt     = r_k + 3'd1;
                  w_state_nxt = ST_ISSUE;
               end
            end else begin
               w_state_nxt = ST_POLL;
            end
         end
         ST_RDLO: begin
            reg_read    = 1'b1;
            reg_addr    = REG_NEXT;
            w_rdata_nxt = {r_rdata[15:8], reg_data_out};
            w_k_nxt     = 3'd5;
            w_state_nxt = ST_ISSUE;
         end
         ST_DONE: begin
            ack         = r_win ? 2'b10 : 2'b01;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign rdata      = r_rdata;
   assign host_rdata = reg_data_out;

endmodule

// File: tb/tb_spi_flash_arb.sv
// Directed and randomized checks of spi_flash_arb against a behavioural
// spi/flash model and a flash-content reference.
module tb_spi_flash_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [23:0] addr0, addr1;
   logic [1:0]  ack;
   logic [15:0] rdata;
   logic        host_lock, host_granted;
   logic [2:0]  host_addr;
   logic [7:0]  host_data;
   logic [1:0]  host_sel;
   logic        host_read, host_write;
   logic [7:0]  host_rdata;
   logic [2:0]  reg_addr;
   logic [7:0]  reg_data_in;
   logic [1:0]  reg_sel;
   logic        reg_read, reg_write;
   logic [7:0]  reg_data_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_flash_arb dut (
      .clk(clk), .reset(reset), .req(req), .addr0(addr0), .addr1(addr1),
      .ack(ack), .rdata(rdata), .host_lock(host_lock), .host_granted(host_granted),
      .host_addr(host_addr), .host_data(host_data), .host_sel(host_sel),
      .host_read(host_read), .host_write(host_write), .host_rdata(host_rdata),
      .reg_addr(reg_addr), .reg_data_in(reg_data_in), .reg_sel(reg_sel),
      .reg_read(reg_read), .reg_write(reg_write), .reg_data_out(reg_data_out)
   );

   // Behavioural spi + flash: byte n of a transaction returns flash data for n >= 4
   logic [7:0]  mem [256];
   int          slow = 0;
   logic        m_cs;
   int          m_nbyte;
   int          m_idx;
   logic [23:0] m_fa;
   logic [7:0]  m_rx;
   int          m_busy;
   int          viol = 0;
   int          overlap = 0;
   logic [10:0] wlog [$];

   assign m_idx = (reg_addr == 3'd0) ? 0 : m_nbyte;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cs    <= 1'b0;
         m_nbyte <= 0;
         m_busy  <= 0;
         m_rx    <= 8'h00;
      end else begin
         if (reg_write && m_busy != 0) viol <= viol + 1;
         if (reg_write && reg_addr <= 3'd1) begin
            if (reg_addr == 3'd0) m_cs <= 1'b1;
            wlog.push_back({reg_addr, reg_data_in});
            case (m_idx)
               1: m_fa[23:16] <= reg_data_in;
               2: m_fa[15:8]  <= reg_data_in;
               3: m_fa[7:0]   <= reg_data_in;
               default: ;
            endcase
            m_rx    <= (m_idx >= 4) ? mem[m_fa[7:0] + 8'(m_idx - 4)] : 8'h00;
            m_nbyte <= m_idx + 1;
            m_busy  <= slow * 8;
         end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
         end
         if (reg_read && reg_addr == 3'd0) m_cs <= 1'b0;
      end
   end

   always_comb begin
      reg_data_out = 8'h00;
      if (reg_addr == 3'd2) reg_data_out = {7'd0, (m_busy == 0)};
      else if (reg_addr <= 3'd1) reg_data_out = m_rx;
   end

   always @(negedge clk) if (ack == 2'b11) overlap <= overlap + 1;

   function automatic logic [15:0] exp_word(input logic [23:0] a);
      logic [7:0] lo;
      lo = a[7:0];
      return {mem[lo + 8'd1], mem[lo]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(output logic [1:0] got, output int cyc);
      got = 2'b00;
      cyc = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (ack != 2'b00) begin
            got = ack;
            break;
         end
      end
      chk("ack_seen", 32'(got != 2'b00), 32'd1);
   endtask

   task automatic run_one(input int port, input logic [23:0] a);
      logic [1:0] got;
      int cyc;
      if (port == 0) addr0 = a; else addr1 = a;
      req = (port == 0) ? 2'b01 : 2'b10;
      wait_ack(got, cyc);
      req = 2'b00;
      chk("rand_port", 32'(got), (port == 0) ? 32'd1 : 32'd2);
      chk("rand_rdata", 32'(rdata), 32'(exp_word(a)));
   endtask

   initial begin
      logic [1:0]  got;
      int          cyc;
      logic [10:0] exp_log [6];
      logic [2:0]  ha;
      logic [7:0]  hd;
      logic [1:0]  hs;
      logic        found;

      reset = 1'b0; req = 2'b00; addr0 = 24'd0; addr1 = 24'd0;
      host_lock = 1'b0; host_addr = 3'd0; host_data = 8'd0; host_sel = 2'd0;
      host_read = 1'b0; host_write = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_host_granted", 32'(host_granted), 32'd0);
      chk("rst_reg_read", 32'(reg_read), 32'd0);
      chk("rst_reg_write", 32'(reg_write), 32'd0);
      chk("rst_reg_addr", 32'(reg_addr), 32'd0);
      chk("rst_reg_data_in", 32'(reg_data_in), 32'd0);
      chk("rst_reg_sel", 32'(reg_sel), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Directed single read on port 0
      mem[8'h45] = 8'hAA;
      mem[8'h46] = 8'h55;
      exp_log[0] = {3'd0, 8'h03};
      exp_log[1] = {3'd1, 8'h01};
      exp_log[2] = {3'd1, 8'h23};
      exp_log[3] = {3'd1, 8'h45};
      exp_log[4] = {3'd1, 8'hFF};
      exp_log[5] = {3'd1, 8'hFF};
      wlog.delete();
      addr0 = 24'h012345;
      req = 2'b01;
      wait_ack(got, cyc);
      chk("t1_cs_released", 32'(m_cs), 32'd0);
      req = 2'b00;
      chk("t1_port", 32'(got), 32'd1);
      chk("t1_rdata", 32'(rdata), 32'h55AA);
      chk("t1_latency", 32'(cyc), 32'd23);
      chk("t1_nwrites", 32'(wlog.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < wlog.size()) chk("t1_write", 32'(wlog[i]), 32'(exp_log[i]));
      end

      // Both ports from reset: service alternates 0,1,0,1
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      addr0 = 24'($urandom);
      addr1 = 24'($urandom);
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_ack(got, cyc);
         chk("rr_port", 32'(got), (i % 2 == 0) ? 32'd1 : 32'd2);
         chk("rr_rdata", 32'(rdata), 32'(exp_word(got[1] ? addr1 : addr0)));
      end
      req = 2'b00;
      @(posedge clk); #1;

      // Random ports, addresses and spi speeds
      for (int i = 0; i < 6; i++) begin
         slow = (i == 0) ? 3 : int'($urandom_range(0, 3));
         run_one(int'($urandom_range(0, 1)), 24'($urandom));
      end
      slow = 0;
      @(posedge clk); #1;

      // Host lock while idle with req1 pending
      addr1 = 24'($urandom);
      host_lock = 1'b1;
      req = 2'b10;
      @(posedge clk); #1;
      chk("host_granted", 32'(host_granted), 32'd1);
      ha = 3'd4 + 3'($urandom_range(0, 3));
      hd = 8'($urandom);
      hs = 2'($urandom);
      host_addr = ha; host_data = hd; host_sel = hs;
      host_write = 1'b1; host_read = 1'b1;
      #1;
      chk("host_addr_pass", 32'(reg_addr), 32'(ha));
      chk("host_data_pass", 32'(reg_data_in), 32'(hd));
      chk("host_sel_pass", 32'(reg_sel), 32'(hs));
      chk("host_write_pass", 32'(reg_write), 32'd1);
      chk("host_read_pass", 32'(reg_read), 32'd1);
      host_addr = 3'd2; host_write = 1'b0;
      #1;
      chk("host_rdata_pass", 32'(host_rdata), 32'h01);
      repeat (5) @(posedge clk);
      #1;
      chk("host_req_held", 32'(ack), 32'd0);
      host_lock = 1'b0; host_addr = 3'd0; host_data = 8'd0; host_sel = 2'd0;
      host_read = 1'b0; host_write = 1'b0;
      wait_ack(got, cyc);
      req = 2'b00;
      chk("host_after_port", 32'(got), 32'd2);
      chk("host_after_rdata", 32'(rdata), 32'(exp_word(addr1)));

      // Host lock raised mid-transaction waits for ack
      addr0 = 24'($urandom);
      req = 2'b01;
      repeat (5) @(posedge clk);
      #1;
      host_lock = 1'b1;
      wait_ack(got, cyc);
      req = 2'b00;
      chk("mid_lock_port", 32'(got), 32'd1);
      chk("mid_lock_not_granted", 32'(host_granted), 32'd0);
      chk("mid_lock_rdata", 32'(rdata), 32'(exp_word(addr0)));
      repeat (2) @(posedge clk);
      #1;
      chk("mid_lock_granted", 32'(host_granted), 32'd1);
      host_lock = 1'b0;
      @(posedge clk); #1;

      // Reset during POLL after the last address byte
      slow = 3;
      addr0 = 24'($urandom);
      req = 2'b01;
      found = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (m_nbyte == 4 && reg_read && reg_addr == 3'd2) begin
            found = 1'b1;
            break;
         end
      end
      chk("poll_k3_reached", 32'(found), 32'd1);
      reset = 1'b0;
      req = 2'b00;
      #1;
      chk("arst_ack", 32'(ack), 32'd0);
      chk("arst_rdata", 32'(rdata), 32'd0);
      chk("arst_host_granted", 32'(host_granted), 32'd0);
      chk("arst_reg_read", 32'(reg_read), 32'd0);
      chk("arst_reg_write", 32'(reg_write), 32'd0);
      chk("arst_reg_addr", 32'(reg_addr), 32'd0);
      chk("arst_reg_data_in", 32'(reg_data_in), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      slow = 0;
      @(posedge clk); #1;
      run_one(0, 24'($urandom));

      chk("no_write_while_busy", 32'(viol), 32'd0);
      chk("no_ack_overlap", 32'(overlap), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_flash_arb.md
# spi_flash_arb

Read controller and arbiter that sits in front of the `spi` register interface and shares one SPI NOR flash channel between two 16-bit read requesters (port 0 instruction fetch, port 1 data load). For each granted request it sequences a standard 0x03 read: command byte, 24-bit address, two data bytes. It then returns one 16-bit little-endian word. A host-lock mode hands the raw register bus to the CPU for flash programming and status access.

## Interface
Parameters:
- SPI_SEL, 2'd0, value driven on `reg_sel` (flash chip-select channel)
- CMD_READ, 8'h03, flash read opcode

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req  in  2  read request per port, held until ack
- addr0, addr1  in  24 each  byte address per port, stable while req
- ack  out  2  one-cycle pulse per port, rdata valid that cycle
- rdata  out  16  {byte@addr+1, byte@addr}
- host_lock  in  1  CPU requests raw register bus
- host_granted  out  1  bus is owned by host
- host_addr in 3, host_data in 8, host_sel in 2, host_read in 1, host_write in 1  raw register bus from CPU
- host_rdata  out  8  `reg_data_out` passthrough, always
- reg_addr out 3, reg_data_in out 8, reg_sel out 2, reg_read out 1, reg_write out 1  to spi
- reg_data_out  in  8  from spi (combinational read data)

## Operation
- SPI register usage: write addr 0 starts a transaction (CS low) and sends a byte; write addr 1 sends the next byte; read addr 1 returns the last received byte with no side effect; read addr 0 returns the last byte and ends the transaction (CS high); read addr 2 bit 0 = ready.
- States: IDLE, HOST, ISSUE, SKIP, POLL, RDLO, DONE. A byte index k (3 bits) tracks sequence progress.
- IDLE: if host_lock -> HOST; the host has priority over pending reqs. Otherwise, if any req, latch winner and address -> ISSUE with k=0.
- Arbitration: round-robin, 2-way. Single req wins. If both assert, the port not granted last wins. After reset, last=1, so port 0 wins first.
- ISSUE (one cycle, `reg_write`=1):
  - k=0: addr 0, CMD_READ.
  - k=1..3: addr 1, A[23:16], A[15:8], A[7:0].
  - k=4, k=5: addr 1, 8'hFF.
  - Then -> SKIP.
- ISSUE (k=6, one cycle, `reg_read`=1): addr 0; capture `reg_data_out` into rdata[15:8]; -> SKIP.
- SKIP: one idle cycle, so the spi ready flag reflects the new operation. Then -> POLL.
- POLL: `reg_read`=1 at addr 2 every cycle until `reg_data_out[0]`=1. Then:
  - if k=4 -> RDLO;
  - if k=6 -> DONE;
  - otherwise k++ and -> ISSUE.
- RDLO: `reg_read` at addr 1; capture `reg_data_out` into rdata[7:0]; k=5; -> ISSUE.
- DONE: ack[winner]=1 for one cycle; update last; -> IDLE.
- HOST: `reg_*` = `host_*` combinationally; host_granted=1. When host_lock=0 -> IDLE next cycle.
- Outside HOST: `reg_sel`=SPI_SEL; `reg_read`/`reg_write` are 0 except as stated above.

## Timing
- Reset values: state IDLE, ack 0, rdata 0, host_granted 0, reg_read 0, reg_write 0, reg_addr 0, reg_data_in 0, last 1.
- Latency from grant to ack with an instant-ready spi: 7 ISSUE + 7 SKIP + 7 POLL + RDLO + DONE = 23 cycles minimum. Actual latency is dominated by spi bit timing.
- A req deasserted before ack is a protocol violation; the transaction completes and ack is still pulsed.
- Simultaneous host_lock and req in IDLE: HOST wins, and req stays pending.
- host_lock asserted mid-transaction is ignored until IDLE. host_granted only rises from IDLE.
- Reset mid-transaction: asynchronous return to IDLE. The system resets spi in the same event, so CS is released there.
- ack never overlaps for both ports. A back-to-back req on the same port re-arbitrates in the cycle after DONE.

## Structure
- Package `spi_ctl_pkg` holds:
  - the state enum;
  - SPI register offsets: REG_XFER=0, REG_NEXT=1, REG_READY=2;
  - FLASH_DUMMY=8'hFF;
  - the default CMD_READ.
- Sub-module `spi_rr_arb2`: 2-way round-robin arbiter with req[1:0], advance, grant one-hot, and registered last.
- Top-level implementation is the sequencer plus the host mux only.

## Test plan
- Single req0, addr0=24'h012345; the flash model returns 8'hAA, 8'h55 -> writes observed in order: addr0 03, then addr1 01, 23, 45, FF, FF. Then ack[0] with rdata=16'h55AA, and CS high before ack.
- req0 and req1 asserted together from reset -> port 0 is served first, then port 1. Both stay asserted -> service alternates 0,1,0,1.
- Spi with clk_count=8'd3 (slow) -> POLL holds; there is no `reg_write` while ready=0, and rdata is still correct.
- host_lock asserted while idle, with req1 also asserted -> host_granted=1 next cycle and host write/read pass through unchanged. req1 is served only after host_lock drops.
- host_lock asserted mid-transaction -> no effect until ack, then host_granted=1.
- reset driven low during a POLL at k=3 -> all outputs return to their reset values immediately. After release, a new req0 completes normally.
